mem_bus_arbiter: RTL and testbench

//  Two-master arbiter sharing the single CPU-side memory port (TempRam data RAM

---
 rtl/mem_bus_arbiter_if.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//  Bundles the two requester ports (M0 core, M1 DMA/debug), the shared memory
//  port and the arbiter status signals.
//  slave  : arbiter view. Takes the requests and mem_rdata. Drives the acks,
//           the per-master read data, the memory strobes, busy and owner.
//  master : environment view (requesters plus memory). This is the mirror of slave.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_we, m0_ack;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_ack;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_write, mem_read;
  logic              busy, owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    input  busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//  Shares one memory port between two masters. The arbiter handles one
//  transaction at a time. In IDLE it latches the winning request. In ISSUE it
//  pulses a single write or read strobe. For a read, it then waits READ_LATENCY
//  cycles and captures the data. In RESP it returns a one-cycle ack to the owner.
//  Ports:
//   CoreClock  : clock. All state changes on the rising edge.
//   CoreReset  : asynchronous, active-high reset. It drops any transaction in flight.
//   bus        : slave modport of mem_bus_arbiter_if (requests, acks, memory, status).
//  Parameters:
//   READ_LATENCY : 1..4. This is the number of cycles from mem_read until mem_rdata is valid.
//   FIXED_PRIO   : 0 gives round-robin on a tie. 1 means M0 always wins.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input logic              CoreClock,
  input logic              CoreReset,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // The counter is loaded with READ_LATENCY-1. The capture happens on the WAIT
  // cycle where the counter reaches 0. That cycle is exactly READ_LATENCY cycles after the strobe.
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_t                 r_state, w_state_nxt;
  logic [1:0]             w_req;
  logic                   w_win;
  logic                   w_mem_write, w_mem_read, w_busy;
  logic [1:0]             w_ack;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata, r_cap;
  logic [1:0][DATA_W-1:0] r_rdata;
  logic                   r_we, r_owner, r_last;
  logic [1:0]             r_cnt;

  assign w_req = {bus.m1_req, bus.m0_req};

  // On a tie, the winner is M0 under fixed priority. Otherwise the winner is
  // whoever did not win last. r_last resets to 1, so M0 takes the first tie.
  always_comb begin
    w_win = w_req[1];
    if (&w_req) w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
  end

  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_write = 1'b0;
    w_mem_read  = 1'b0;
    w_ack       = 2'b00;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (|w_req) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_mem_write = r_we;
        w_mem_read  = ~r_we;
        w_state_nxt = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: if (r_cnt == 2'd0) w_state_nxt = S_RESP;
      S_RESP: begin
        w_ack[r_owner] = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (|w_req) begin
          r_owner <= w_win;
          r_we    <= w_win ? bus.m1_we    : bus.m0_we;
          r_addr  <= w_win ? bus.m1_addr  : bus.m0_addr;
          r_wdata <= w_win ? bus.m1_wdata : bus.m0_wdata;
        end
        S_ISSUE: r_cnt <= LAT_M1;
        S_WAIT: begin
          if (r_cnt == 2'd0) r_cap <= bus.mem_rdata;
          else               r_cnt <= r_cnt - 2'd1;
        end
        S_RESP: begin
          r_last <= r_owner;
          if (!r_we) r_rdata[r_owner] <= r_cap;
        end
        default: ;
      endcase
    end
  end

  // During a read ack, the captured word is presented straight away. The
  // per-master copy is updated on the same edge, so it holds the value afterwards.
  assign bus.m0_rdata  = (w_ack[0] && !r_we) ? r_cap : r_rdata[0];
  assign bus.m1_rdata  = (w_ack[1] && !r_we) ? r_cap : r_rdata[1];
  assign bus.m0_ack    = w_ack[0];
  assign bus.m1_ack    = w_ack[1];
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_read  = w_mem_read;
  assign bus.busy      = w_busy;
  assign bus.owner     = r_owner;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//  There are three arbiter instances:
//   inst 0: READ_LATENCY=1, round-robin
//   inst 1: READ_LATENCY=1, fixed priority
//   inst 2: READ_LATENCY=4, round-robin
//  Each instance has a small RAM model. Outside the one valid cycle, that model
//  returns junk on mem_rdata. An expected-ack queue is filled when requests are
//  driven. It is drained by a monitor that watches every ack.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0][1:0]         t_req, t_we;
  logic [NI-1:0][1:0][AW-1:0] t_addr;
  logic [NI-1:0][1:0][DW-1:0] t_wdata;

  wire [NI-1:0][1:0]         w_ack;
  wire [NI-1:0][1:0][DW-1:0] w_rdata;
  wire [NI-1:0]              w_wr, w_rd, w_busy, w_own;
  wire [NI-1:0][AW-1:0]      w_maddr;
  wire [NI-1:0][DW-1:0]      w_mwdata;

  typedef struct {
    int          k;
    int          m;
    logic [31:0] rd;
    bit          we;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RL = (g == 2) ? 4 : 1;
    localparam int FP = (g == 1) ? 1 : 0;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .FIXED_PRIO(FP)
    ) u_dut (
      .CoreClock(clk),
      .CoreReset(rst),
      .bus      (bus)
    );

    logic [DW-1:0] ram [0:63];
    logic [DW-1:0] rd_val = '0;
    int            rd_cnt = 0;
    always @(posedge clk) begin
      if (bus.mem_write) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
      if (bus.mem_read) begin
        rd_val <= ram[bus.mem_addr[7:2]];
        rd_cnt <= RL;
      end else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    end
    assign bus.mem_rdata = (rd_cnt == 1) ? rd_val : (DW'(cyc) ^ 32'hBAD0_0000);

    assign bus.m0_req   = t_req[g][0];
    assign bus.m0_we    = t_we[g][0];
    assign bus.m0_addr  = t_addr[g][0];
    assign bus.m0_wdata = t_wdata[g][0];
    assign bus.m1_req   = t_req[g][1];
    assign bus.m1_we    = t_we[g][1];
    assign bus.m1_addr  = t_addr[g][1];
    assign bus.m1_wdata = t_wdata[g][1];

    assign w_ack[g]    = {bus.m1_ack, bus.m0_ack};
    assign w_rdata[g]  = {bus.m1_rdata, bus.m0_rdata};
    assign w_wr[g]     = bus.mem_write;
    assign w_rd[g]     = bus.mem_read;
    assign w_busy[g]   = bus.busy;
    assign w_own[g]    = bus.owner;
    assign w_maddr[g]  = bus.mem_addr;
    assign w_mwdata[g] = bus.mem_wdata;
  end

  // The scoreboard monitor checks every ack against the expected-ack queue. It
  // also checks that the write and read strobes never overlap.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (w_wr[k] || w_rd[k]) chk("strobe_excl", 32'(w_wr[k] & w_rd[k]), 32'd0);
      for (int m = 0; m < 2; m++) begin
        if (w_ack[k][m]) begin
          chk("ack_pending", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack_inst", k, e.k);
            chk("ack_mst", m, e.m);
            if (!e.we) chk("rdata", w_rdata[k][m], e.rd);
          end
        end
      end
    end
  end

  // This task runs a single transaction with the request driven in the cycle-0 IDLE.
  // It checks the strobe and the fields at cycle 1, then the ack latency. It drops
  // the request at the ack cycle.
  task automatic txn(input int k, input int m, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input int lat);
    int n;
    @(negedge clk);
    t_req[k][m]   = 1'b1;
    t_we[k][m]    = we;
    t_addr[k][m]  = a;
    t_wdata[k][m] = d;
    sb.push_back('{k, m, exp_rd, we});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("strobe", 32'(we ? w_wr[k] : w_rd[k]), 32'd1);
        chk("maddr", w_maddr[k], a);
        if (we) chk("mwdata", w_mwdata[k], d);
      end
    end while (!w_ack[k][m] && n < 20);
    chk("lat", n, lat);
    chk("other_ack", 32'(w_ack[k][1-m]), 32'd0);
    chk("owner", 32'(w_own[k]), m);
    chk("busy", 32'(w_busy[k]), 32'd1);
    t_req[k][m] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int g, n;
    t_req = '0; t_we = '0; t_addr = '0; t_wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", 32'(w_busy[k]), 32'd0);
      chk("rst_owner", 32'(w_own[k]), 32'd0);
      chk("rst_strb", 32'(w_wr[k] | w_rd[k]), 32'd0);
      chk("rst_ack", 32'(w_ack[k]), 32'd0);
      chk("rst_maddr", w_maddr[k], 32'd0);
    end
    rst = 1'b0;

    // Basic write and read on M0, then on M1. The M0 read data must survive the M1 read.
    txn(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 2);
    txn(0, 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
    txn(0, 1, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 2);
    txn(0, 1, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 3);
    chk("m0_rdata_hold", w_rdata[0][0], 32'hDEADBEEF);

    // Round-robin with both requests held. The last winner was M1, so M0 leads.
    @(negedge clk);
    t_we[0] = 2'b11; t_addr[0][0] = 32'h20; t_addr[0][1] = 32'h24;
    t_wdata[0][0] = 32'hA0A0A0A0; t_wdata[0][1] = 32'hB1B1B1B1;
    t_req[0] = 2'b11;
    for (int i = 0; i < 4; i++) sb.push_back('{0, i % 2, 32'h0, 1'b1});
    g = 0; n = 0;
    while (g < 4 && n < 40) begin
      @(negedge clk); n++;
      if (w_wr[0]) chk("rr_owner", 32'(w_own[0]), g % 2);
      if (|w_ack[0]) begin
        g++;
        if (g == 4) t_req[0] = 2'b00;
      end
    end
    chk("rr_grants", g, 4);

    // Fixed priority: M0 keeps winning until it drops its request.
    @(negedge clk);
    t_we[1] = 2'b11; t_addr[1][0] = 32'h30; t_addr[1][1] = 32'h34;
    t_wdata[1][0] = 32'h11112222; t_wdata[1][1] = 32'h33334444;
    t_req[1] = 2'b11;
    for (int i = 0; i < 4; i++) sb.push_back('{1, (i == 3) ? 1 : 0, 32'h0, 1'b1});
    g = 0; n = 0;
    while (g < 4 && n < 40) begin
      @(negedge clk); n++;
      if (w_wr[1]) chk("fp_owner", 32'(w_own[1]), (g < 3) ? 0 : 1);
      if (|w_ack[1]) begin
        g++;
        if (g == 3) t_req[1][0] = 1'b0;
        if (g == 4) t_req[1][1] = 1'b0;
      end
    end
    chk("fp_grants", g, 4);

    // Reset during WAIT of an M1 read on the latency-4 instance.
    // M0 goes first, so without the reset M1 would win the next tie.
    txn(2, 0, 1'b1, 32'h40, 32'h12345678, 32'h0, 2);
    @(negedge clk);
    t_we[2][1] = 1'b0; t_addr[2][1] = 32'h40; t_req[2][1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(w_busy[2]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(w_busy[2]), 32'd0);
    chk("arst_strb", 32'(w_wr[2] | w_rd[2]), 32'd0);
    chk("arst_ack", 32'(w_ack[2]), 32'd0);
    chk("arst_maddr", w_maddr[2], 32'd0);
    repeat (2) @(negedge clk);
    t_req[2][1] = 1'b0;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_m1_ack", 32'(sb.size()), 32'd0);

    // After the reset, M0 must win the tie.
    @(negedge clk);
    t_we[2] = 2'b11; t_addr[2][0] = 32'h44; t_addr[2][1] = 32'h48;
    t_wdata[2][0] = 32'h55; t_wdata[2][1] = 32'h66;
    t_req[2] = 2'b11;
    sb.push_back('{2, 0, 32'h0, 1'b1});
    n = 0;
    while (!(|w_ack[2]) && n < 20) begin
      @(negedge clk); n++;
    end
    chk("tie_m0_ack", 32'(w_ack[2]), 32'd1);
    t_req[2] = 2'b00;

    // Latency-4 read. The captured word must be the one from cycle 5 only.
    txn(2, 1, 1'b0, 32'h40, 32'h0, 32'h12345678, 6);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
